pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 33 +++
 rtl/pipe_stage_reg_en_reg.sv | 33 +++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared types and constants for the skid-buffered pipeline
//               stage: state encoding, occupancy width, occupancy decode.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

   // Width of the occupancy output (holds 0, 1 or 2).
   localparam int COUNT_W = 2;

   // Stage occupancy state. Encoding 2'b11 is unused and recovers to EMPTY.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b10
   } state_t;

   // Number of entries held for a given state; the unused code reports zero.
   function automatic logic [COUNT_W-1:0] state_count(input state_t s);
      logic [COUNT_W-1:0] n;
      case (s)
         ST_EMPTY: n = 2'd0;
         ST_BUSY:  n = 2'd1;
         ST_FULL:  n = 2'd2;
         default:  n = 2'd0;
      endcase
      return n;
   endfunction

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_en_reg.sv
`default_nettype none
// ============================================================================
// Module      : en_reg
// Description : WIDTH-bit load-enable register with asynchronous active-low
//               reset to RESET_VAL. Holds its value whenever en_i is low.
// Revision    : 1.0 - initial release
// ============================================================================
module en_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // Capture d_i only when enabled; reset forces the configured value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= RESET_VAL;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule : en_reg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry valid/ready pipeline stage (main + skid register).
//               in_ready, out_valid and count are decoded from the state
//               register only, so no combinational path runs from out_ready
//               to in_ready. out_data comes straight from the main register.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ready,
   output logic [COUNT_W-1:0] count
);

   state_t           state_q;
   state_t           state_d;

   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_main_en;
   logic             w_main_sel_skid;
   logic             w_skid_en;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   // Handshakes use the state-decoded flags, never raw inputs alone.
   assign w_in_fire  = in_valid  & in_ready;
   assign w_out_fire = out_valid & out_ready;

   // Main refills from the skid when draining FULL, otherwise from upstream.
   assign w_main_d   = w_main_sel_skid ? skid_q : in_data;

   // State register: async reset to EMPTY.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and data-register load enables; flush overrides everything
   // and suppresses every load so the main register keeps its last value.
   always_comb begin
      state_d         = state_q;
      w_main_en       = 1'b0;
      w_main_sel_skid = 1'b0;
      w_skid_en       = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_main_en = 1'b1;
                  state_d   = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_in_fire && w_out_fire) begin
                  // Head leaves while the new entry takes its place.
                  w_main_en = 1'b1;
               end else if (w_in_fire) begin
                  // Head stalled: park the newcomer in the skid register.
                  w_skid_en = 1'b1;
                  state_d   = ST_FULL;
               end else if (w_out_fire) begin
                  state_d   = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  w_main_en       = 1'b1;
                  w_main_sel_skid = 1'b1;
                  state_d         = ST_BUSY;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Status outputs decoded purely from the state register.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      count     = state_count(state_q);
      case (state_q)
         ST_EMPTY: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         ST_BUSY: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
         end
         ST_FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   en_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (w_main_en),
      .d_i  (w_main_d),
      .q_o  (main_q)
   );

   en_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_skid_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (w_skid_en),
      .d_i  (in_data),
      .q_o  (skid_q)
   );

   assign out_data = main_q;

endmodule : pipe_stage_reg
`default_nettype wire
